// File: rtl/tgen_pkg.sv
// Shared definitions for the DDR2 traffic generator.
// Contents: FSM state encoding and the per-transfer data pattern function.
// The pattern is built at MAX_DATA_W bits. Users truncate it to their own
// data width, which must be a multiple of 32 and no more than MAX_DATA_W.
package tgen_pkg;

  localparam int unsigned MAX_DATA_W = 512;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned IDX_W      = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    CHECK   = 3'd5,
    DONE    = 3'd6
  } state_t;

  // Data for one transfer: {idx, ~idx} XOR seed, repeated across the bus.
  function automatic logic [MAX_DATA_W-1:0] pattern(input logic [IDX_W-1:0]  idx,
                                                    input logic [WORD_W-1:0] seed);
    logic [WORD_W-1:0] word;
    word = {idx, ~idx} ^ seed;
    return {(MAX_DATA_W/WORD_W){word}};
  endfunction

endpackage

// File: rtl/tgen_addr_gen.sv
// Transfer index counter with address and data generation for ddr2_traffic_gen.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   clr      - restart at transfer 0 (address START_ADDR)
//   inc      - advance to the next transfer (address += ADDR_STRIDE)
//   addr     - address of the current transfer (registered, wraps modulo 2^ADDR_W)
//   data_c   - pattern data of the current transfer (combinational from the index)
//   last_c   - current transfer is transfer NUM_XFERS-1
module tgen_addr_gen
  import tgen_pkg::*;
#(
  parameter int unsigned ADDR_W      = 26,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned NUM_XFERS   = 16,
  parameter int unsigned START_ADDR  = 0,
  parameter int unsigned ADDR_STRIDE = 1,
  parameter logic [31:0] SEED        = 32'h5A5A_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_c,
  output logic              last_c
);

  logic [IDX_W-1:0] idx;

  // Address is stepped incrementally so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      addr <= '0;
    end else if (clr) begin
      idx  <= '0;
      addr <= ADDR_W'(START_ADDR);
    end else if (inc) begin
      idx  <= idx + IDX_W'(1);
      addr <= addr + ADDR_W'(ADDR_STRIDE);
    end
  end

  assign data_c = DATA_W'(pattern(idx, SEED));
  assign last_c = (idx == IDX_W'(NUM_XFERS - 1));

endmodule

// File: rtl/ddr2_traffic_gen.sv
// DDR2 controller traffic generator: writes a seeded pattern to NUM_XFERS
// addresses, reads it back, and counts mismatches.
// Optional feature: define TGEN_TIMEOUT_EN to add parameter TIMEOUT_CYC and
// output timeout. This aborts a run that stays too long in one state.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   start             - pulse that begins a run (ignored while busy)
//   c_addr, c_data_in - request address and write data to the controller
//   c_rd_req/c_wr_req - request strobes, held until c_ack
//   c_ack, c_rdy      - controller accept and idle/read-valid
//   c_data_out        - read data from the controller
//   busy, done, pass  - run status; pass is valid while done=1
//   err_count         - saturating read mismatch count
//   first_err_addr    - address of the first mismatch
//   timeout           - (TGEN_TIMEOUT_EN only) run aborted by the watchdog
module ddr2_traffic_gen
  import tgen_pkg::*;
#(
  parameter int unsigned ADDR_W      = 26,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned NUM_XFERS   = 16,
  parameter int unsigned START_ADDR  = 0,
  parameter int unsigned ADDR_STRIDE = 1,
  parameter int unsigned INTERLEAVE  = 0,
  parameter logic [31:0] SEED        = 32'h5A5A_0000
`ifdef TGEN_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_data_in,
  output logic              c_rd_req,
  output logic              c_wr_req,
  input  logic              c_ack,
  input  logic              c_rdy,
  input  logic [DATA_W-1:0] c_data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr
`ifdef TGEN_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  state_t            state, state_d;
  logic              rd_req_d, wr_req_d, busy_d, done_d, pass_d;
  logic [ADDR_W-1:0] addr_d, first_err_addr_d;
  logic [DATA_W-1:0] data_in_d, rd_data, rd_data_d;
  logic [15:0]       err_count_d;
  logic              rdy_q;
  logic              rdy_rise_c;
  logic              mismatch_c;
  logic              gen_clr, gen_inc;
  logic [ADDR_W-1:0] gen_addr;
  logic [DATA_W-1:0] gen_data_c;
  logic              gen_last_c;

  tgen_addr_gen #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .NUM_XFERS   (NUM_XFERS),
    .START_ADDR  (START_ADDR),
    .ADDR_STRIDE (ADDR_STRIDE),
    .SEED        (SEED)
  ) u_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (gen_clr),
    .inc    (gen_inc),
    .addr   (gen_addr),
    .data_c (gen_data_c),
    .last_c (gen_last_c)
  );

  // A completion is a registered rising edge of c_rdy. In the cycle where
  // c_ack is taken the FSM is still in *_REQ, so an edge coinciding with
  // c_ack is never seen by *_WAIT (rdy_q is already 1 there).
  assign rdy_rise_c = c_rdy & ~rdy_q;
  assign mismatch_c = (rd_data != gen_data_c);

`ifdef TGEN_TIMEOUT_EN
  logic        timeout_d;
  logic [31:0] tcnt;
  logic        tmo_hit_c;

  // Cycles spent in the current active state; restarts on every transition.
  assign tmo_hit_c = busy && ((tcnt + 32'd1) >= 32'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst || !busy || (state_d != state)) tcnt <= '0;
    else                                    tcnt <= tcnt + 32'd1;
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d          = state;
    wr_req_d         = c_wr_req;
    rd_req_d         = c_rd_req;
    addr_d           = c_addr;
    data_in_d        = c_data_in;
    busy_d           = busy;
    done_d           = done;
    pass_d           = pass;
    err_count_d      = err_count;
    first_err_addr_d = first_err_addr;
    rd_data_d        = rd_data;
    gen_clr          = 1'b0;
    gen_inc          = 1'b0;
`ifdef TGEN_TIMEOUT_EN
    timeout_d        = timeout;
`endif

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d          = WR_REQ;
          gen_clr          = 1'b1;
          busy_d           = 1'b1;
          done_d           = 1'b0;
          pass_d           = 1'b0;
          err_count_d      = '0;
          first_err_addr_d = '0;
`ifdef TGEN_TIMEOUT_EN
          timeout_d        = 1'b0;
`endif
        end
      end

      WR_REQ: begin
        if (!c_wr_req) begin
          if (c_rdy) begin
            wr_req_d  = 1'b1;
            addr_d    = gen_addr;
            data_in_d = gen_data_c;
          end
        end else if (c_ack) begin
          wr_req_d = 1'b0;
          state_d  = WR_WAIT;
        end
      end

      WR_WAIT: begin
        if (rdy_rise_c) begin
          if (INTERLEAVE != 0) begin
            state_d = RD_REQ;
          end else if (gen_last_c) begin
            gen_clr = 1'b1;
            state_d = RD_REQ;
          end else begin
            gen_inc = 1'b1;
            state_d = WR_REQ;
          end
        end
      end

      RD_REQ: begin
        if (!c_rd_req) begin
          if (c_rdy) begin
            rd_req_d = 1'b1;
            addr_d   = gen_addr;
          end
        end else if (c_ack) begin
          rd_req_d = 1'b0;
          state_d  = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (rdy_rise_c) begin
          rd_data_d = c_data_out;
          state_d   = CHECK;
        end
      end

      CHECK: begin
        if (mismatch_c) begin
          if (err_count != 16'hFFFF) err_count_d = err_count + 16'd1;
          if (err_count == 16'd0)    first_err_addr_d = gen_addr;
        end
        if (gen_last_c) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == 16'd0);
        end else begin
          gen_inc = 1'b1;
          state_d = (INTERLEAVE != 0) ? WR_REQ : RD_REQ;
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef TGEN_TIMEOUT_EN
    // Watchdog overrides whatever the state machine decided.
    if (tmo_hit_c) begin
      state_d   = DONE;
      wr_req_d  = 1'b0;
      rd_req_d  = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      pass_d    = 1'b0;
      timeout_d = 1'b1;
      gen_clr   = 1'b0;
      gen_inc   = 1'b0;
    end
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      c_addr         <= '0;
      c_data_in      <= '0;
      c_rd_req       <= 1'b0;
      c_wr_req       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      rd_data        <= '0;
      rdy_q          <= 1'b0;
`ifdef TGEN_TIMEOUT_EN
      timeout        <= 1'b0;
`endif
    end else begin
      state          <= state_d;
      c_addr         <= addr_d;
      c_data_in      <= data_in_d;
      c_rd_req       <= rd_req_d;
      c_wr_req       <= wr_req_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      err_count      <= err_count_d;
      first_err_addr <= first_err_addr_d;
      rd_data        <= rd_data_d;
      rdy_q          <= c_rdy;
`ifdef TGEN_TIMEOUT_EN
      timeout        <= timeout_d;
`endif
    end
  end

endmodule

// File: doc/ddr2_traffic_gen.md
DDR2_TRAFFIC_GEN -- requirements
Module: ddr2_traffic_gen

Interface
REQ-001 Parameter ADDR_W, 26: width of c_addr.
REQ-002 Parameter DATA_W, 64: width of c_data_in and c_data_out; multiple of 32.
REQ-003 Parameter NUM_XFERS, 16: transfers per run, range 1..65535.
REQ-004 Parameter START_ADDR, 0: address of transfer 0.
REQ-005 Parameter ADDR_STRIDE, 1: address increment per transfer.
REQ-006 Parameter INTERLEAVE, 0: 0 = all writes then all reads; 1 = write/read pair per transfer.
REQ-007 Parameter SEED, 32'h5A5A_0000: pattern seed.
REQ-008 Port list (name, direction, width, meaning):
- clk, in, 1: the single clock.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: one-cycle pulse that begins a run.
- c_addr, out, ADDR_W: controller address.
- c_data_in, out, DATA_W: write data to the controller.
- c_rd_req, out, 1: read request.
- c_wr_req, out, 1: write request.
- c_ack, in, 1: controller accepted the request.
- c_rdy, in, 1: controller idle; also marks read data valid.
- c_data_out, in, DATA_W: read data from the controller.
- busy, out, 1: a run is in progress.
- done, out, 1: run finished; held until the next start or rst.
- pass, out, 1: valid while done=1.
- err_count, out, 16: number of read mismatches, saturating.
- first_err_addr, out, ADDR_W: address of the first mismatch.

Function
REQ-009 States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, DONE.
REQ-010 IDLE->WR_REQ on start. start is ignored while busy=1. start in DONE clears done/pass/err_count and begins a new run.
REQ-011 Address of transfer i SHALL be START_ADDR + i*ADDR_STRIDE, truncated modulo 2^ADDR_W (wrap-around allowed).
REQ-012 Data for transfer i SHALL be {DATA_W/32 copies of {i[15:0], ~i[15:0]}} XOR {DATA_W/32 copies of SEED}.
REQ-013 Request handshake:
- Assert the request only while c_rdy=1.
- Hold c_addr, c_data_in and the request stable until c_ack is sampled high.
- Deassert the request on the next cycle.
REQ-014 WR_WAIT/RD_WAIT: wait for a registered rising edge of c_rdy, i.e. c_rdy=1 with its previous value 0.
REQ-015 In RD_WAIT, capture c_data_out on the c_rdy rising-edge cycle. CHECK compares it to the expected data one cycle later.
REQ-016 On mismatch: increment err_count, saturating at 16'hFFFF. Load first_err_addr only when err_count was 0.
REQ-017 Sequence with INTERLEAVE=0: NUM_XFERS writes, then NUM_XFERS reads. With INTERLEAVE=1: write i, then read i, for each i.
REQ-018 After the last CHECK: go to DONE, done=1, busy=0, pass=(err_count==0).
REQ-019 c_rd_req and c_wr_req SHALL never be high in the same cycle.
REQ-020 If c_ack and a c_rdy rising edge occur in the same cycle, c_ack is consumed first. That c_rdy edge does not complete the transfer.

Reset
REQ-021 rst (synchronous, active-high) SHALL force state IDLE and drive all outputs to 0. This includes c_addr, c_data_in, requests, busy, done, pass, err_count and first_err_addr.
REQ-022 rst mid-transfer SHALL drop any asserted request in the same cycle it is sampled. The run is abandoned and is not resumed.

Configuration
REQ-023 Macro TGEN_TIMEOUT_EN, when defined:
- Add parameter TIMEOUT_CYC, default 4096.
- Add output timeout, 1 bit.
- A counter runs in every non-IDLE/non-DONE state and reloads on each state change.
- When it reaches TIMEOUT_CYC: drop requests, go to DONE with done=1, pass=0, timeout=1.
- timeout clears on start or rst.
REQ-024 Without TGEN_TIMEOUT_EN: no timeout counter, port or parameter exists, and the block waits indefinitely.

Structure
REQ-025 A shared package tgen_pkg SHALL hold the state enum and the pattern function (index, seed -> data).
REQ-026 One sub-module, tgen_addr_gen, SHALL hold the transfer index counter and the address/data generator. The FSM and checker stay at top level.

Verification
REQ-027 NUM_XFERS=4, INTERLEAVE=0, ideal memory model -> 4 writes, then 4 reads to addresses 0..3; done=1, pass=1, err_count=0.
REQ-028 INTERLEAVE=1, NUM_XFERS=2, START_ADDR=26'h3FFFFFF, STRIDE=1 -> write/read at 26'h3FFFFFF, then at 26'h0000000 (wrap); pass=1.
REQ-029 Model flips bit 0 of read data at address 2 (NUM_XFERS=4) -> err_count=1, first_err_addr=2, pass=0.
REQ-030 rst pulsed while c_wr_req=1 -> next cycle c_wr_req=0, busy=0, done=0. A later start runs a full clean pass.
REQ-031 With TGEN_TIMEOUT_EN, TIMEOUT_CYC=16, c_ack tied 0 -> done=1, timeout=1, pass=0 within 17 cycles of the request.
REQ-032 start pulsed while busy=1 -> ignored, and the run completes unchanged. Every cycle of every test SHALL have c_rd_req&c_wr_req=0.
